alu_share_arbiter: RTL and testbench

- Shares the single ALU between the CPU datapath and the DMA module.
- Each requester presents operands plus a 3-bit ALU function code.
- The arbiter picks one requester, drives registered operands and function into the ALU, captures the result, and returns it with a one-cycle done pulse.
- CPU has fixed priority; a starvation counter guarantees DMA forward progress.

---
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Arbitrates one shared ALU between the CPU datapath and the DMA engine.
// CPU has fixed priority; a saturating starvation counter forces a DMA win after STARVE_MAX losses.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [WIDTH-1:0] cpu_a,
  input  logic [WIDTH-1:0] cpu_b,
  input  logic [2:0]       cpu_funct,
  input  logic             dma_req,
  input  logic [WIDTH-1:0] dma_a,
  input  logic [WIDTH-1:0] dma_b,
  input  logic [2:0]       dma_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             cpu_done,
  output logic             dma_done,
  output logic             busy,
  output logic             owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_nxt_s;
  logic       grant_s;
  logic       pick_dma_s;

  // Next-state, winner selection and starvation-count update
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_cnt_r;
    grant_s      = 1'b0;
    pick_dma_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          grant_s     = 1'b1;
          pick_dma_s  = dma_req & (~cpu_req | (starve_cnt_r == STARVE_LIM));
          state_nxt_s = ST_EXEC;
          // DMA losing a contested round moves it closer to a forced win
          if (pick_dma_s) begin
            starve_nxt_s = 4'd0;
          end else if (dma_req && (starve_cnt_r < STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_nxt_s = starve_cnt_r;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand latch, result capture and done pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= 4'd0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_funct    <= 3'd0;
      result       <= '0;
      result_zero  <= 1'b0;
      cpu_done     <= 1'b0;
      dma_done     <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      busy         <= (state_nxt_s != ST_IDLE);
      cpu_done     <= (state_r == ST_EXEC) & ~owner;
      dma_done     <= (state_r == ST_EXEC) & owner;
      if (grant_s) begin
        alu_a     <= pick_dma_s ? dma_a : cpu_a;
        alu_b     <= pick_dma_s ? dma_b : cpu_b;
        alu_funct <= pick_dma_s ? dma_funct : cpu_funct;
        owner     <= pick_dma_s;
      end
      if (state_r == ST_EXEC) begin
        result      <= alu_y;
        result_zero <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed literal scenarios plus random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int WIDTH      = 32;
  localparam int STARVE_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_req, dma_req;
  logic [WIDTH-1:0] cpu_a, cpu_b, dma_a, dma_b;
  logic [2:0]       cpu_funct, dma_funct;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y, result;
  logic [2:0]       alu_funct;
  logic             alu_zero, result_zero, cpu_done, dma_done, busy, owner;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_b(cpu_b), .cpu_funct(cpu_funct),
    .dma_req(dma_req), .dma_a(dma_a), .dma_b(dma_b), .dma_funct(dma_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .result(result), .result_zero(result_zero),
    .cpu_done(cpu_done), .dma_done(dma_done), .busy(busy), .owner(owner)
  );

  // Environment ALU
  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {{(WIDTH-1){1'b0}}, (a < b)};
      default: return a ^ b;
    endcase
  endfunction

  assign alu_y    = alu_fn(alu_a, alu_b, alu_funct);
  assign alu_zero = (alu_y == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an operation occupies three cycles (grant, execute, respond)
  int               m_cycles_left = 0;
  int               m_starve      = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]       m_f = 3'd0;
  logic             m_owner = 1'b0, m_rz = 1'b0, m_cd = 1'b0, m_dd = 1'b0, m_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cycles_left <= 0;  m_starve <= 0;
      m_a <= '0; m_b <= '0; m_f <= 3'd0; m_res <= '0; m_rz <= 1'b0;
      m_owner <= 1'b0; m_cd <= 1'b0; m_dd <= 1'b0; m_busy <= 1'b0;
    end else if (m_cycles_left == 0) begin
      if (cpu_req || dma_req) begin
        m_cycles_left <= 2;
        m_busy        <= 1'b1;
        if (dma_req && (!cpu_req || m_starve == STARVE_MAX)) begin
          m_owner <= 1'b1; m_a <= dma_a; m_b <= dma_b; m_f <= dma_funct;
          m_starve <= 0;
        end else begin
          m_owner <= 1'b0; m_a <= cpu_a; m_b <= cpu_b; m_f <= cpu_funct;
          if (dma_req) m_starve <= (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        end
      end
    end else if (m_cycles_left == 2) begin
      m_cycles_left <= 1;
      m_res <= alu_fn(m_a, m_b, m_f);
      m_rz  <= (alu_fn(m_a, m_b, m_f) == '0);
      m_cd  <= !m_owner;
      m_dd  <= m_owner;
    end else begin
      m_cycles_left <= 0;
      m_busy <= 1'b0; m_cd <= 1'b0; m_dd <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("alu_a",       64'(alu_a),       64'(m_a));
      chk("alu_b",       64'(alu_b),       64'(m_b));
      chk("alu_funct",   64'(alu_funct),   64'(m_f));
      chk("result",      64'(result),      64'(m_res));
      chk("result_zero", 64'(result_zero), 64'(m_rz));
      chk("cpu_done",    64'(cpu_done),    64'(m_cd));
      chk("dma_done",    64'(dma_done),    64'(m_dd));
      chk("busy",        64'(busy),        64'(m_busy));
      chk("owner",       64'(owner),       64'(m_owner));
      chk("done_excl",   64'(cpu_done & dma_done), 64'd0);
    end
  end

  task automatic single_op(input bit use_dma, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] f, input logic [WIDTH-1:0] exp_res, input bit exp_z);
    if (use_dma) begin
      dma_req = 1'b1; dma_a = a; dma_b = b; dma_funct = f;
    end else begin
      cpu_req = 1'b1; cpu_a = a; cpu_b = b; cpu_funct = f;
    end
    @(negedge clk);
    chk("op_owner", 64'(owner), 64'(use_dma));
    chk("op_alu_a", 64'(alu_a), 64'(a));
    @(negedge clk);
    chk("op_done", 64'(use_dma ? dma_done : cpu_done), 64'd1);
    chk("op_other_done", 64'(use_dma ? cpu_done : dma_done), 64'd0);
    chk("op_result", 64'(result), 64'(exp_res));
    chk("op_zero", 64'(result_zero), 64'(exp_z));
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("op_idle", 64'(busy), 64'd0);
  endtask

  // Both requesters held high; owners must follow the starvation pattern
  task automatic contention(input int n_ops);
    cpu_req = 1'b1; dma_req = 1'b1;
    cpu_a = 32'd1; cpu_b = 32'd2; cpu_funct = 3'b010;
    dma_a = 32'd10; dma_b = 32'd3; dma_funct = 3'b110;
    for (int k = 0; k < n_ops; k++) begin
      @(negedge clk);
      chk("cont_owner", 64'(owner), 64'((k % 4) == 3));
      @(negedge clk);
      chk("cont_dma_done", 64'(dma_done), 64'((k % 4) == 3));
      chk("cont_cpu_done", 64'(cpu_done), 64'((k % 4) != 3));
      chk("cont_result", 64'(result), ((k % 4) == 3) ? 64'd7 : 64'd3);
      @(negedge clk);
      chk("cont_idle", 64'(busy), 64'd0);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_a = 32'd5; cpu_b = 32'd3; cpu_funct = 3'b010;
    dma_req = 1'b0; dma_a = '0; dma_b = '0; dma_funct = 3'd0;

    // Reset held two cycles with a pending CPU request
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_done", 64'(cpu_done), 64'd0);
    rst_n = 1'b1;

    // First grant at the edge right after release
    @(negedge clk);
    chk("cpu_grant_busy", 64'(busy), 64'd1);
    chk("cpu_grant_a", 64'(alu_a), 64'd5);
    chk("cpu_grant_b", 64'(alu_b), 64'd3);
    @(negedge clk);
    chk("cpu_done", 64'(cpu_done), 64'd1);
    chk("cpu_result", 64'(result), 64'd8);
    chk("cpu_zero", 64'(result_zero), 64'd0);
    chk("cpu_dma_done", 64'(dma_done), 64'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_after_idle", 64'(busy), 64'd0);

    single_op(1'b1, 32'h100, 32'd4, 3'b110, 32'hFC, 1'b0);
    single_op(1'b1, 32'd7, 32'd7, 3'b110, 32'd0, 1'b1);

    contention(8);
    @(negedge clk);

    // Operand change during EXEC is ignored; the held request is re-serviced with the new value
    cpu_req = 1'b1; cpu_a = 32'd5; cpu_b = 32'd3; cpu_funct = 3'b010;
    @(negedge clk);
    chk("stab_alu_a", 64'(alu_a), 64'd5);
    cpu_a = 32'd9;
    @(negedge clk);
    chk("stab_result", 64'(result), 64'd8);
    @(negedge clk);
    chk("stab_idle", 64'(busy), 64'd0);
    @(negedge clk);
    chk("stab_alu_a2", 64'(alu_a), 64'd9);
    @(negedge clk);
    chk("stab_result2", 64'(result), 64'd12);
    cpu_req = 1'b0;
    @(negedge clk);

    // Reset during EXEC after one CPU win; the count must restart from zero
    cpu_req = 1'b1; dma_req = 1'b1;
    @(negedge clk);
    chk("mid_owner", 64'(owner), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_cpu_done", 64'(cpu_done), 64'd0);
    chk("mid_dma_done", 64'(dma_done), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    contention(4);
    @(negedge clk);

    // Random traffic, occasional resets, small operands to hit the zero flag
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 149) != 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      dma_req   = ($urandom_range(0, 2) != 0);
      cpu_a     = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      cpu_b     = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      dma_a     = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      dma_b     = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      cpu_funct = 3'($urandom_range(0, 7));
      dma_funct = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    rst_n = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) @(negedge clk);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
